fetch_aligner: RTL and testbench

//  Sequences instruction fetch for the RVC-capable front end: issues word-aligned fetches, buffers 16-bit

---
 rtl/fetch_aligner.sv | 144 ++++++++++++++
 tb/tb_fetch_aligner.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// fetch_aligner: word-fetch sequencer, 16-bit parcel buffer and RVC-aware instruction issue.
// Build option: define FETCH_ALIGNER_ILLEGAL_EN to flag the all-zero compressed parcel as illegal.
//
// state    | meaning
// FS_IDLE  | no fetch outstanding
// FS_WAIT  | fetch outstanding, its response will be appended to the buffer
// FS_STALE | fetch outstanding across a flush, its response will be dropped
module fetch_aligner #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          PBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic [15:0] dec_cin,
    input  logic [31:0] dec_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_c,
    output logic        instr_illegal
);

    localparam int CW = $clog2(PBUF_DEPTH + 1);

    typedef enum logic [1:0] {FS_IDLE, FS_WAIT, FS_STALE} fetchState_t;

    fetchState_t fState, fStateNext;

    logic [PBUF_DEPTH-1:0][15:0] pbuf, pbufShift, pbufNext;
    logic [CW-1:0] count, countNext, appendBase;
    logic [31:0]   headPc;
    logic          dropLow;
    logic [15:0]   p0, p1, appendLo;
    logic          p0IsC, outFree, issue, respAccept, roomNext;
    logic [1:0]    popN, appendN;
    logic [31:0]   issueInstr;

    assign p0         = pbuf[0];
    assign p1         = pbuf[1];
    assign p0IsC      = (p0[1:0] != 2'b11);
    assign outFree    = !instr_valid || instr_ready;
    assign issue      = outFree && !flush &&
                        (((count != '0) && p0IsC) || (count >= CW'(2)));
    assign popN       = !issue ? 2'd0 : (p0IsC ? 2'd1 : 2'd2);
    assign respAccept = (fState == FS_WAIT) && fetch_valid && !flush;
    assign appendN    = !respAccept ? 2'd0 : (dropLow ? 2'd1 : 2'd2);
    assign appendLo   = dropLow ? fetch_data[31:16] : fetch_data[15:0];
    assign dec_cin    = (count != '0) ? p0 : 16'h0000;

    // Pop shifts the buffer toward entry 0; new parcels land right after the survivors.
    assign pbufShift  = pbuf >> {popN, 4'b0000};
    assign appendBase = count - CW'(popN);
    assign countNext  = flush ? '0 : (appendBase + CW'(appendN));
    assign roomNext   = (countNext <= CW'(PBUF_DEPTH - 2));

    always_comb begin
        pbufNext = pbufShift;
        for (int i = 0; i < PBUF_DEPTH; i++) begin
            if (appendN != 2'd0 && CW'(i) == appendBase) pbufNext[i] = appendLo;
            if (appendN == 2'd2 && CW'(i) == appendBase + CW'(1)) pbufNext[i] = fetch_data[31:16];
        end
    end

    always_comb begin
        fStateNext = fState;
        case (fState)
            FS_IDLE:  if (roomNext) fStateNext = FS_WAIT;
            FS_WAIT: begin
                if (fetch_valid)  fStateNext = roomNext ? FS_WAIT : FS_IDLE;
                else if (flush)   fStateNext = FS_STALE;
            end
            FS_STALE: if (fetch_valid) fStateNext = FS_WAIT;
            default:  fStateNext = FS_IDLE;
        endcase
    end

    assign fetch_req = (fState != FS_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fState     <= FS_IDLE;
            pbuf       <= '0;
            count      <= '0;
            fetch_addr <= RESET_PC & ~32'h3;
            headPc     <= RESET_PC;
            dropLow    <= 1'b0;
        end else begin
            fState <= fStateNext;
            pbuf   <= pbufNext;
            count  <= countNext;
            if (flush) begin
                fetch_addr <= redirect_pc & ~32'h3;
                headPc     <= redirect_pc & ~32'h1;
                dropLow    <= redirect_pc[1];
            end else begin
                if (respAccept) begin
                    fetch_addr <= fetch_addr + 32'd4;
                    dropLow    <= 1'b0;
                end
                if (issue) headPc <= headPc + (p0IsC ? 32'd2 : 32'd4);
            end
        end
    end

`ifdef FETCH_ALIGNER_ILLEGAL_EN
    logic p0Zero;
    assign p0Zero     = p0IsC && (p0 == 16'h0000);
    assign issueInstr = p0Zero ? 32'h0000_0000 : (p0IsC ? dec_out : {p1, p0});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                instr_illegal <= 1'b0;
        else if (issue && !flush) instr_illegal <= p0Zero;
    end
`else
    assign issueInstr    = p0IsC ? dec_out : {p1, p0};
    assign instr_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_is_c  <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (issue) begin
            instr_valid <= 1'b1;
            instr       <= issueInstr;
            instr_pc    <= headPc;
            instr_is_c  <= p0IsC;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed and randomized checks of fetch_aligner against a parcel-walking model.
// Honours FETCH_ALIGNER_ILLEGAL_EN the same way the design does.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic [15:0] dec_cin;
    logic [31:0] dec_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_c;
    logic        instr_illegal;

    always #5 clk = ~clk;

    fetch_aligner dut (
        .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .dec_cin(dec_cin), .dec_out(dec_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_is_c(instr_is_c), .instr_illegal(instr_illegal)
    );

    int total = 0;
    int bad = 0;

    // Stand-in decompressor: real C.ADDI expansion, everything else a recognisable tag.
    function automatic logic [31:0] decomp(input logic [15:0] c);
        logic [31:0] imm;
        if (c[1:0] == 2'b01 && c[15:13] == 3'b000) begin
            imm = {{26{c[12]}}, c[12], c[6:2]};
            return {imm[11:0], c[11:7], 3'b000, c[11:7], 7'b0010011};
        end
        return {~c, c};
    endfunction

    assign dec_out = decomp(dec_cin);

    logic [31:0] mem [256];

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: walk the halfword stream from a PC; length decided by the low two bits.
    task automatic modelAt(input logic [31:0] pc, output logic [31:0] ins, output logic isC,
                           output logic ill, output logic [31:0] nextPc);
        logic [15:0] a;
        a = hw(pc);
        if (a[1:0] != 2'b11) begin
            isC = 1'b1;
            nextPc = pc + 32'd2;
`ifdef FETCH_ALIGNER_ILLEGAL_EN
            ill = (a == 16'h0000);
            ins = ill ? 32'h0 : decomp(a);
`else
            ill = 1'b0;
            ins = decomp(a);
`endif
        end else begin
            isC = 1'b0;
            ill = 1'b0;
            ins = {hw(pc + 32'd2), a};
            nextPc = pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction memory responder with randomized latency.
    int minLat = 0;
    int maxLat = 0;
    bit busy = 0;
    int lat = 0;
    logic [31:0] reqAddr = '0;

    initial begin
        forever begin
            @(negedge clk);
            fetch_valid = 1'b0;
            if (!rst) begin
                busy = 0;
            end else if (fetch_req) begin
                chk("fetch_addr_align", 32'(fetch_addr[1:0]), 32'd0);
                if (!busy) begin
                    busy = 1;
                    reqAddr = fetch_addr;
                    lat = $urandom_range(maxLat, minLat);
                end
                if (lat == 0) begin
                    fetch_valid = 1'b1;
                    fetch_data = mem[reqAddr[9:2]];
                    busy = 0;
                end else begin
                    lat--;
                end
            end
        end
    end

    int cyc = 0;
    int readyMode = 1;
    bit flushReq = 0;
    logic [31:0] flushPc = '0;
    logic [31:0] expPc = '0;
    bit hold = 0;
    logic [31:0] hInstr, hPc;
    logic hIsC, hIll;
    logic [31:0] logPc[$];
    logic [31:0] logIns[$];
    logic logIsC[$];
    logic logIll[$];
    int logCyc[$];

    task automatic step();
        logic [31:0] eIns, eNext;
        logic eIsC, eIll;
        @(negedge clk);
        cyc++;
        if (hold) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, hInstr);
            chk("hold_pc", instr_pc, hPc);
            chk("hold_is_c", 32'(instr_is_c), 32'(hIsC));
            chk("hold_illegal", 32'(instr_illegal), 32'(hIll));
        end
        flush = flushReq;
        redirect_pc = flushPc;
        if (flushReq)            instr_ready = 1'b0;
        else if (readyMode == 1) instr_ready = 1'b1;
        else if (readyMode == 0) instr_ready = 1'b0;
        else                     instr_ready = 1'($urandom_range(1, 0));
        if (flushReq) begin
            expPc = flushPc & ~32'h1;
            flushReq = 0;
        end else if (instr_valid && instr_ready) begin
            modelAt(expPc, eIns, eIsC, eIll, eNext);
            chk("instr", instr, eIns);
            chk("instr_pc", instr_pc, expPc);
            chk("instr_is_c", 32'(instr_is_c), 32'(eIsC));
            chk("instr_illegal", 32'(instr_illegal), 32'(eIll));
            logPc.push_back(instr_pc);
            logIns.push_back(instr);
            logIsC.push_back(instr_is_c);
            logIll.push_back(instr_illegal);
            logCyc.push_back(cyc);
            expPc = eNext;
        end
        hold = instr_valid && !instr_ready && !flush;
        hInstr = instr;
        hPc = instr_pc;
        hIsC = instr_is_c;
        hIll = instr_illegal;
    endtask

    task automatic chkResetState(input string tag);
        chk({tag, "_fetch_req"}, 32'(fetch_req), 32'd0);
        chk({tag, "_fetch_addr"}, fetch_addr, 32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_is_c"}, 32'(instr_is_c), 32'd0);
        chk({tag, "_illegal"}, 32'(instr_illegal), 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        flush = 1'b0;
        flushReq = 0;
        instr_ready = 1'b0;
        #1;
        chkResetState("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        hold = 0;
        expPc = 32'h0;
        logPc.delete(); logIns.delete(); logIsC.delete(); logIll.delete(); logCyc.delete();
        step();
        chk("req_after_reset", 32'(fetch_req), 32'd1);
    endtask

    function automatic logic [15:0] randParcel();
        if ($urandom_range(9, 0) == 0) return 16'h0000;
        return 16'($urandom);
    endfunction

    task automatic fillNops();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) mem[i] = {randParcel(), randParcel()};
    endtask

    task automatic runUntil(input int n, input int budget);
        for (int i = 0; i < budget && logPc.size() < n; i++) step();
        chk("handshake_count", 32'(logPc.size() >= n), 32'd1);
    endtask

    initial begin
        int base;
        int nBefore;

        // 1: two compressed parcels from word 0, back to back
        fillNops();
        mem[0] = 32'h04C5_0001;
        readyMode = 1; minLat = 0; maxLat = 0;
        doReset();
        runUntil(2, 40);
        if (logPc.size() >= 2) begin
            chk("t1_instr0", logIns[0], 32'h0000_0013);
            chk("t1_pc0", logPc[0], 32'h0);
            chk("t1_isc0", 32'(logIsC[0]), 32'd1);
            chk("t1_instr1", logIns[1], 32'h0114_8493);
            chk("t1_pc1", logPc[1], 32'h2);
            chk("t1_isc1", 32'(logIsC[1]), 32'd1);
            chk("t1_b2b", 32'(logCyc[1] - logCyc[0]), 32'd1);
        end

        // 2: 32-bit instruction straddling words 0 and 1
        fillRandom();
        mem[0] = 32'h0093_0001;
        mem[1] = 32'h0001_0010;
        doReset();
        runUntil(3, 60);
        if (logPc.size() >= 3) begin
            chk("t2_instr0", logIns[0], 32'h0000_0013);
            chk("t2_pc0", logPc[0], 32'h0);
            chk("t2_instr1", logIns[1], 32'h0010_0093);
            chk("t2_pc1", logPc[1], 32'h2);
            chk("t2_isc1", 32'(logIsC[1]), 32'd0);
            chk("t2_instr2", logIns[2], 32'h0000_0013);
            chk("t2_pc2", logPc[2], 32'h6);
        end

        // 3: decode stalls; output must hold, fetch must stop once the buffer is full
        readyMode = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t3_valid_held", 32'(instr_valid), 32'd1);
        chk("t3_fetch_stalled", 32'(fetch_req), 32'd0);
        nBefore = logPc.size();
        readyMode = 1;
        for (int i = 0; i < 30; i++) step();
        chk("t3_resumed", 32'(logPc.size() > nBefore), 32'd1);

        // 4: flush to 0x102 while the first fetch is outstanding
        fillNops();
        mem[0]  = 32'h04C5_04C5;
        mem[64] = 32'h0001_1111;
        minLat = 3; maxLat = 3;
        doReset();
        for (int i = 0; i < 10 && !fetch_req; i++) step();
        chk("t4_req_up", 32'(fetch_req), 32'd1);
        flushReq = 1; flushPc = 32'h0000_0102;
        step();
        step();
        chk("t4_fetch_addr", fetch_addr, 32'h0000_0100);
        chk("t4_req_held", 32'(fetch_req), 32'd1);
        chk("t4_valid_cleared", 32'(instr_valid), 32'd0);
        minLat = 0; maxLat = 0;
        base = logPc.size();
        runUntil(base + 1, 40);
        if (logPc.size() > base) begin
            chk("t4_first_pc", logPc[base], 32'h0000_0102);
            chk("t4_first_instr", logIns[base], 32'h0000_0013);
        end

        // 5: reset asserted mid-stream
        fillRandom();
        minLat = 0; maxLat = 2; readyMode = 2;
        doReset();
        for (int i = 0; i < 25; i++) step();
        readyMode = 2;
        doReset();
        runUntil(1, 60);
        if (logPc.size() >= 1) chk("t5_restart_pc", logPc[0], 32'h0);

        // 6: all-zero compressed parcel
        fillNops();
        mem[0] = 32'h0001_0000;
        readyMode = 1; minLat = 0; maxLat = 0;
        doReset();
        runUntil(1, 40);
        if (logPc.size() >= 1) begin
`ifdef FETCH_ALIGNER_ILLEGAL_EN
            chk("t6_illegal", 32'(logIll[0]), 32'd1);
            chk("t6_instr", logIns[0], 32'h0);
`else
            chk("t6_illegal", 32'(logIll[0]), 32'd0);
            chk("t6_instr", logIns[0], 32'hFFFF_0000);
`endif
        end

        // Random: latency, back-pressure and redirects, including one across the 2^32 wrap
        fillRandom();
        minLat = 0; maxLat = 3; readyMode = 2;
        doReset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                flushReq = 1; flushPc = 32'hFFFF_FFFA;
            end else if ($urandom_range(49, 0) == 0) begin
                flushReq = 1; flushPc = 32'($urandom_range(32'h3FF, 0));
            end
            step();
        end
        chk("rand_progress", 32'(logPc.size() > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
